// File: rtl/pc_unit.sv
// Program-counter unit for the RV32I core: holds the fetch PC and picks the next one from
// sequential step, redirect, trap entry or trap return, with stall, halt/resume and misalign trapping.
module pc_unit #(
  parameter int unsigned      XLEN        = 32,
  parameter logic [XLEN-1:0]  BASE_PC     = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0]  TRAP_VEC    = XLEN'(32'h0000_0100),
  parameter int unsigned      ALIGN_BYTES = 4,
  parameter int unsigned      CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect_vld,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             trap_req,
  input  logic             trap_ret,
  input  logic             halt_req,
  input  logic             resume,
  output logic [XLEN-1:0]  pc,
  output logic             pc_valid,
  output logic [XLEN-1:0]  epc,
  output logic             misalign_err,
  output logic             halted,
  output logic [CNT_W-1:0] adv_count
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ALIGN_BYTES - 1);
  localparam logic [XLEN-1:0] SEQ_STEP   = XLEN'(4);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state;
  logic   tgt_misaligned_c;

  assign tgt_misaligned_c = |(redirect_pc & ALIGN_MASK);

  // State, PC and status registers; trap entry and misaligned redirects override stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= BASE_PC;
      epc          <= '0;
      pc_valid     <= 1'b0;
      misalign_err <= 1'b0;
      halted       <= 1'b0;
      adv_count    <= '0;
    end else begin
      misalign_err <= 1'b0;
      case (state)
        BOOT: begin
          state    <= RUN;
          pc_valid <= 1'b1;
        end
        RUN: begin
          if (trap_req) begin
            epc <= pc;
            pc  <= TRAP_VEC;
          end else if (redirect_vld && tgt_misaligned_c) begin
            epc          <= pc;
            pc           <= TRAP_VEC;
            misalign_err <= 1'b1;
          end else if (stall) begin
            pc <= pc;
          end else if (trap_ret) begin
            pc        <= epc;
            adv_count <= adv_count + CNT_W'(1);
          end else if (redirect_vld) begin
            pc        <= redirect_pc;
            adv_count <= adv_count + CNT_W'(1);
          end else if (halt_req) begin
            state    <= HALT;
            halted   <= 1'b1;
            pc_valid <= 1'b0;
          end else begin
            pc        <= pc + SEQ_STEP;
            adv_count <= adv_count + CNT_W'(1);
          end
        end
        HALT: begin
          // Resume only re-enables fetch; the PC moves on the following edge.
          if (resume) begin
            state    <= RUN;
            halted   <= 1'b0;
            pc_valid <= 1'b1;
          end
        end
        default: begin
          state    <= BOOT;
          pc_valid <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: a 4-byte-aligned/32-bit-count instance and a
// 2-byte-aligned/4-bit-count instance share stimulus and are checked against a reference model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect_vld, trap_req, trap_ret, halt_req, resume;
  logic [31:0] redirect_pc;

  logic [31:0] pc_a, epc_a, cnt_a;
  logic        pc_valid_a, misalign_a, halted_a;
  logic [31:0] pc_b, epc_b;
  logic [3:0]  cnt_b;
  logic        pc_valid_b, misalign_b, halted_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_unit dut_a (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_vld(redirect_vld),
    .redirect_pc(redirect_pc), .trap_req(trap_req), .trap_ret(trap_ret),
    .halt_req(halt_req), .resume(resume), .pc(pc_a), .pc_valid(pc_valid_a),
    .epc(epc_a), .misalign_err(misalign_a), .halted(halted_a), .adv_count(cnt_a)
  );

  pc_unit #(.ALIGN_BYTES(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_vld(redirect_vld),
    .redirect_pc(redirect_pc), .trap_req(trap_req), .trap_ret(trap_ret),
    .halt_req(halt_req), .resume(resume), .pc(pc_b), .pc_valid(pc_valid_b),
    .epc(epc_b), .misalign_err(misalign_b), .halted(halted_b), .adv_count(cnt_b)
  );

  // Reference model: mode 0=boot, 1=running, 2=halted; index 0 is dut_a, 1 is dut_b.
  int          m_mode [2];
  logic [31:0] m_pc   [2];
  logic [31:0] m_epc  [2];
  logic [31:0] m_cnt  [2];
  logic        m_valid[2];
  logic        m_mis  [2];
  logic        m_halt [2];
  int unsigned m_align[2] = '{4, 2};
  longint unsigned m_cmod[2] = '{64'h1_0000_0000, 64'h10};

  logic [98:0] obs_a, exp_a;
  logic [70:0] obs_b, exp_b;
  assign obs_a = {pc_a, pc_valid_a, epc_a, misalign_a, halted_a, cnt_a};
  assign exp_a = {m_pc[0], m_valid[0], m_epc[0], m_mis[0], m_halt[0], m_cnt[0]};
  assign obs_b = {pc_b, pc_valid_b, epc_b, misalign_b, halted_b, cnt_b};
  assign exp_b = {m_pc[1], m_valid[1], m_epc[1], m_mis[1], m_halt[1], m_cnt[1][3:0]};

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_pc[i] = 32'h0; m_epc[i] = 32'h0; m_cnt[i] = 32'h0;
      m_valid[i] = 1'b0; m_mis[i] = 1'b0; m_halt[i] = 1'b0;
    end
  endfunction

  function automatic void advance(int i);
    m_cnt[i] = 32'((longint'(m_cnt[i]) + 1) % m_cmod[i]);
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        model_reset();
        continue;
      end
      m_mis[i] = 1'b0;
      if (m_mode[i] == 0) begin
        m_mode[i] = 1; m_valid[i] = 1'b1;
      end else if (m_mode[i] == 2) begin
        if (resume) begin m_mode[i] = 1; m_halt[i] = 1'b0; m_valid[i] = 1'b1; end
      end else if (trap_req) begin
        m_epc[i] = m_pc[i]; m_pc[i] = 32'h100;
      end else if (redirect_vld && (redirect_pc % m_align[i]) != 0) begin
        m_epc[i] = m_pc[i]; m_pc[i] = 32'h100; m_mis[i] = 1'b1;
      end else if (stall) begin
        // hold
      end else if (trap_ret) begin
        m_pc[i] = m_epc[i]; advance(i);
      end else if (redirect_vld) begin
        m_pc[i] = redirect_pc; advance(i);
      end else if (halt_req) begin
        m_mode[i] = 2; m_halt[i] = 1'b1; m_valid[i] = 1'b0;
      end else begin
        m_pc[i] = 32'((longint'(m_pc[i]) + 4) % 64'h1_0000_0000); advance(i);
      end
    end
  endfunction

  task automatic clear_inputs();
    stall = 0; redirect_vld = 0; redirect_pc = 32'h0; trap_req = 0;
    trap_ret = 0; halt_req = 0; resume = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0; redirect_vld = 1'b1; redirect_pc = 32'h1234_5678;
    model_reset();
    step(); step();
    total++; if (pc_a !== 32'h0 || pc_valid_a !== 1'b0) begin bad++;
      $display("FAIL reset_hold: pc=%h valid=%b want 00000000/0", pc_a, pc_valid_a); end
    total++; if (obs_a !== exp_a) begin bad++;
      $display("FAIL reset_state: got %h want %h", obs_a, exp_a); end
    rst_n = 1'b1; clear_inputs();
    step();
    total++; if (pc_a !== 32'h0 || pc_valid_a !== 1'b1) begin bad++;
      $display("FAIL boot_exit: pc=%h valid=%b want 00000000/1", pc_a, pc_valid_a); end
    step();
    total++; if (pc_a !== 32'h4) begin bad++; $display("FAIL seq_first: pc=%h want 4", pc_a); end
    step();
    total++; if (pc_a !== 32'h8 || cnt_a !== 32'd2) begin bad++;
      $display("FAIL seq_second: pc=%h cnt=%0d want 8/2", pc_a, cnt_a); end
    total++; if (obs_b !== exp_b) begin bad++;
      $display("FAIL boot_b: got %h want %h", obs_b, exp_b); end
  endtask

  task automatic test_redirect_stall();
    logic [31:0] cnt_save;
    redirect_vld = 1; redirect_pc = 32'h1000_0000;
    step();
    clear_inputs();
    total++; if (pc_a !== 32'h1000_0000) begin bad++;
      $display("FAIL redirect: pc=%h want 10000000", pc_a); end
    cnt_save = cnt_a;
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (pc_a !== 32'h1000_0000 || cnt_a !== cnt_save) begin bad++;
        $display("FAIL stall_hold: pc=%h cnt=%0d want 10000000/%0d", pc_a, cnt_a, cnt_save); end
    end
    trap_req = 1;
    step();
    clear_inputs();
    total++; if (pc_a !== 32'h100 || epc_a !== 32'h1000_0000) begin bad++;
      $display("FAIL stall_trap: pc=%h epc=%h want 100/10000000", pc_a, epc_a); end
    total++; if (obs_a !== exp_a || obs_b !== exp_b) begin bad++;
      $display("FAIL stall_model: a=%h/%h b=%h/%h", obs_a, exp_a, obs_b, exp_b); end
  endtask

  task automatic test_misalign();
    redirect_vld = 1; redirect_pc = 32'h8;
    step();
    redirect_pc = 32'hA;
    step();
    clear_inputs();
    total++; if (pc_a !== 32'h100 || epc_a !== 32'h8 || misalign_a !== 1'b1) begin bad++;
      $display("FAIL misalign_a: pc=%h epc=%h err=%b want 100/8/1", pc_a, epc_a, misalign_a); end
    total++; if (pc_b !== 32'hA || misalign_b !== 1'b0) begin bad++;
      $display("FAIL misalign_b: pc=%h err=%b want a/0", pc_b, misalign_b); end
    step();
    total++; if (misalign_a !== 1'b0) begin bad++;
      $display("FAIL misalign_pulse: err=%b want 0", misalign_a); end
    total++; if (obs_a !== exp_a || obs_b !== exp_b) begin bad++;
      $display("FAIL misalign_model: a=%h/%h b=%h/%h", obs_a, exp_a, obs_b, exp_b); end
  endtask

  task automatic test_trap_ret();
    redirect_vld = 1; redirect_pc = 32'h40;
    step();
    clear_inputs(); trap_req = 1;
    step();
    clear_inputs();
    total++; if (pc_a !== 32'h100 || epc_a !== 32'h40 || pc_b !== 32'h100) begin bad++;
      $display("FAIL trap_entry: pc=%h epc=%h pc_b=%h want 100/40/100", pc_a, epc_a, pc_b); end
    trap_ret = 1; redirect_vld = 1; redirect_pc = 32'h80;
    step();
    clear_inputs();
    total++; if (pc_a !== 32'h40 || pc_b !== 32'h40) begin bad++;
      $display("FAIL trap_ret: pc=%h pc_b=%h want 40/40", pc_a, pc_b); end
    total++; if (obs_a !== exp_a || obs_b !== exp_b) begin bad++;
      $display("FAIL trap_ret_model: a=%h/%h b=%h/%h", obs_a, exp_a, obs_b, exp_b); end
  endtask

  task automatic test_halt();
    redirect_vld = 1; redirect_pc = 32'h20;
    step();
    clear_inputs(); halt_req = 1;
    step();
    clear_inputs();
    total++; if (halted_a !== 1'b1 || pc_valid_a !== 1'b0 || pc_a !== 32'h20) begin bad++;
      $display("FAIL halt_enter: halted=%b valid=%b pc=%h want 1/0/20", halted_a, pc_valid_a, pc_a); end
    trap_req = 1; trap_ret = 1; redirect_vld = 1; redirect_pc = 32'h80;
    for (int k = 0; k < 5; k++) begin
      step();
      total++; if (pc_a !== 32'h20 || halted_a !== 1'b1 || epc_a !== exp_a[65:34]) begin bad++;
        $display("FAIL halt_hold: pc=%h halted=%b epc=%h want 20/1/%h", pc_a, halted_a, epc_a, exp_a[65:34]); end
    end
    clear_inputs(); resume = 1; halt_req = 1;
    step();
    clear_inputs();
    total++; if (halted_a !== 1'b0 || pc_a !== 32'h20 || pc_valid_a !== 1'b1) begin bad++;
      $display("FAIL resume: halted=%b pc=%h valid=%b want 0/20/1", halted_a, pc_a, pc_valid_a); end
    step();
    total++; if (pc_a !== 32'h24) begin bad++; $display("FAIL resume_seq: pc=%h want 24", pc_a); end
    total++; if (obs_a !== exp_a || obs_b !== exp_b) begin bad++;
      $display("FAIL halt_model: a=%h/%h b=%h/%h", obs_a, exp_a, obs_b, exp_b); end
  endtask

  task automatic test_wrap();
    int guard;
    redirect_vld = 1; redirect_pc = 32'hFFFF_FFFC;
    step();
    clear_inputs();
    total++; if (pc_a !== 32'hFFFF_FFFC) begin bad++;
      $display("FAIL wrap_setup: pc=%h want fffffffc", pc_a); end
    step();
    total++; if (pc_a !== 32'h0 || pc_b !== 32'h0) begin bad++;
      $display("FAIL pc_wrap: pc=%h pc_b=%h want 0/0", pc_a, pc_b); end
    guard = 0;
    while (m_cnt[1] != 32'd15 && guard < 20) begin step(); guard++; end
    total++; if (cnt_b !== 4'hF) begin bad++;
      $display("FAIL cnt_pre_wrap: cnt_b=%0d want 15", cnt_b); end
    step();
    total++; if (cnt_b !== 4'h0) begin bad++;
      $display("FAIL cnt_wrap: cnt_b=%0d want 0", cnt_b); end
    total++; if (obs_a !== exp_a || obs_b !== exp_b) begin bad++;
      $display("FAIL wrap_model: a=%h/%h b=%h/%h", obs_a, exp_a, obs_b, exp_b); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      stall        = ($urandom % 8) == 0;
      trap_req     = ($urandom % 16) == 0;
      redirect_vld = ($urandom % 4) == 0;
      redirect_pc  = $urandom;
      if ($urandom % 2 == 1) redirect_pc = redirect_pc & 32'hFFFF_FFFC;
      trap_ret     = ($urandom % 10) == 0;
      halt_req     = ($urandom % 12) == 0;
      resume       = ($urandom % 3) == 0;
      step();
      total++; if (obs_a !== exp_a) begin bad++;
        $display("FAIL random_a[%0d]: got %h want %h", k, obs_a, exp_a); end
      total++; if (obs_b !== exp_b) begin bad++;
        $display("FAIL random_b[%0d]: got %h want %h", k, obs_b, exp_b); end
    end
    clear_inputs();
  endtask

  task automatic test_mid_reset();
    redirect_vld = 1; redirect_pc = 32'h300;
    step();
    rst_n = 1'b0;
    model_reset();
    #2;
    total++; if (pc_a !== 32'h0 || epc_a !== 32'h0 || pc_valid_a !== 1'b0 || misalign_a !== 1'b0 ||
                 halted_a !== 1'b0 || cnt_a !== 32'h0) begin bad++;
      $display("FAIL async_reset: got %h want all zero", obs_a); end
    total++; if (obs_b !== exp_b) begin bad++;
      $display("FAIL async_reset_b: got %h want %h", obs_b, exp_b); end
    #3 rst_n = 1'b1;
    clear_inputs();
    step(); step();
    total++; if (pc_a !== 32'h4 || cnt_a !== 32'd1 || obs_b !== exp_b) begin bad++;
      $display("FAIL post_reset: pc=%h cnt=%0d b=%h want 4/1/%h", pc_a, cnt_a, obs_b, exp_b); end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_redirect_stall();
    test_misalign();
    test_trap_ret();
    test_halt();
    test_wrap();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
